// File: rtl/my_type_fifo_if.sv
// Valid/ready producer and consumer bundle for my_type_fifo, plus debug occupancy.
interface my_type_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic [CW-1:0]    peak;

  // Environment side: drives producer data and consumer ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, peak
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, peak
  );
endinterface

// File: rtl/my_type_fifo.sv
// In-order buffer for my_type_t words between two valid/ready handshakes,
// with occupancy and high-water-mark reporting.
module my_type_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  my_type_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    peak_q;
  logic [CW-1:0]    peak_d;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Handshake qualification; rst_n gates in_ready so nothing lands during reset.
  always_comb begin
    full          = (count_q == CW'(DEPTH));
    empty         = (count_q == '0);
    bus.in_ready  = !full && rst_n;
    bus.out_valid = !empty;
    bus.out_data  = empty ? '0 : mem[rd_ptr];
    push          = bus.in_valid && bus.in_ready;
    pop           = bus.out_valid && bus.out_ready;
  end

  // Next occupancy and high-water mark.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  // Pointer, occupancy and peak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  // Storage array; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.count = count_q;
  assign bus.peak  = peak_q;
endmodule

// File: tb/tb_my_type_fifo.sv
// Directed bench for my_type_fifo with a queue-based reference model.
module tb_my_type_fifo;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  my_type_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  my_type_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_q [$];
  int          m_peak = 0;
  logic [31:0] got [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of accepted words plus a running maximum.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_peak = 0;
    end else begin
      automatic bit do_push = bus.in_valid && (m_q.size() != DEPTH);
      automatic bit do_pop  = bus.out_ready && (m_q.size() != 0);
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(bus.in_data);
      if (m_q.size() > m_peak) m_peak = m_q.size();
    end
  end

  // Cycle compare against the model, plus capture of words the consumer takes.
  always @(negedge clk) begin
    automatic logic [31:0] exp_data = (m_q.size() != 0) ? m_q[0] : 32'h0;
    chk("in_ready",  32'(bus.in_ready),  32'((rst_n === 1'b1) && (m_q.size() != DEPTH)));
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("out_data",  bus.out_data,       exp_data);
    chk("count",     32'(bus.count),     32'(m_q.size()));
    chk("peak",      32'(bus.peak),      32'(m_peak));
    if (rst_n && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain_until(input int n);
    for (int i = 0; i < 30 && got.size() < n; i++) step();
  endtask

  initial begin
    logic [31:0] fill_words [5];
    fill_words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'hDEADBEEF};
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset asserted mid-cycle: values must clear without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_peak",      32'(bus.peak),      32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // Fill to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = fill_words[i];
      step();
    end
    chk("full_count",    32'(bus.count),    32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_peak",     32'(bus.peak),     32'd4);
    bus.in_data = 32'hDEADBEEF;
    step();
    step();
    chk("held_count", 32'(bus.count),    32'd4);
    chk("held_head",  bus.out_data,      32'h11111111);

    // Pop in the full cycle: pop only, then push+pop together.
    got.delete();
    bus.out_ready = 1'b1;
    step();
    chk("fullpop_count",    32'(bus.count),    32'd3);
    chk("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("pushpop_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    drain_until(5);
    chk("drain_len", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("drain_word", got[i], fill_words[i]);
    chk("drain_count", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;

    // Full-rate streaming from a fresh reset.
    reset_pulse();
    got.delete();
    bus.out_ready = 1'b1;
    chk("stream_pre_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      step();
      if (i == 0) chk("stream_first_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    drain_until(100);
    chk("stream_len", 32'(got.size()), 32'd100);
    for (int i = 0; i < 100 && i < got.size(); i++) chk("stream_word", got[i], 32'(i));
    chk("stream_peak", 32'(bus.peak), 32'd1);
    bus.out_ready = 1'b0;

    // Ten rounds of push 3 / pop 3 to wrap both pointers repeatedly.
    for (int r = 0; r < 10; r++) begin
      got.delete();
      for (int k = 0; k < 3; k++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'(r * 16 + k + 32'hA000);
        step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain_until(3);
      bus.out_ready = 1'b0;
      chk("wrap_len", 32'(got.size()), 32'd3);
      for (int k = 0; k < 3 && k < got.size(); k++) chk("wrap_word", got[k], 32'(r * 16 + k + 32'hA000));
      chk("wrap_count", 32'(bus.count), 32'd0);
    end

    // Reset with two words stored discards them and restarts peak.
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h5000 + 32'(k);
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    reset_pulse();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_count", 32'(bus.count),     32'd0);
    chk("post_rst_peak",  32'(bus.peak),      32'd0);
    got.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFEF00D;
    step();
    bus.in_valid = 1'b0;
    chk("cafe_head", bus.out_data,      32'hCAFEF00D);
    chk("cafe_peak", 32'(bus.peak),     32'd1);
    bus.out_ready = 1'b1;
    drain_until(1);
    bus.out_ready = 1'b0;
    chk("cafe_len", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("cafe_word", got[0], 32'hCAFEF00D);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/my_type_fifo.md
# my_type_fifo

Buffered downstream stage for `my_type_t` words (32-bit) produced by the pass-through `dut` stage. It takes the raw word stream on a valid/ready handshake, stores up to DEPTH words in order, and presents them to the consumer on a second valid/ready handshake. It also reports current occupancy and a high-water mark for debug. Its purpose is to decouple consumer stalls from the producer.

## Interface
Parameters:
- `WIDTH`, 32, word width; matches `my_type_t`.
- `DEPTH`, 4, number of storage entries. Must be ≥ 2; power of two not required.
- `CW`, `$clog2(DEPTH+1)`, width of count outputs. Derived; do not override.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_data`  in  WIDTH  producer word (`my_type_t`).
- `in_ready`  out  1  FIFO can accept a word this cycle.
- `out_valid`  out  1  `out_data` holds the oldest stored word.
- `out_data`  out  WIDTH  head-of-queue word; zero when `out_valid`=0.
- `out_ready`  in  1  consumer takes the word this cycle.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `peak`  out  CW  maximum `count` reached since reset.

## Operation
- Storage: DEPTH×WIDTH register array, with write pointer `wr_ptr` and read pointer `rd_ptr`. Each pointer wraps from DEPTH-1 to 0.
- Push:
  - Occurs when `in_valid && in_ready`.
  - Writes `in_data` at `wr_ptr`, then advances `wr_ptr`.
- Pop:
  - Occurs when `out_valid && out_ready`.
  - Advances `rd_ptr`. The storage entry is not cleared.
- `in_ready` = (`count` != DEPTH) && `rst_n`.
  - No pass-through when full: a pop in the full cycle does not allow a same-cycle push.
- `out_valid` = (`count` != 0).
- `out_data` = `mem[rd_ptr]` when `out_valid`, else 0.
- Count update per cycle:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged (only possible when 0 < `count` < DEPTH)
  - neither: unchanged
- `peak` <= max(`peak`, next `count`). It is updated in the same edge as `count`.
- Handshake rules:
  - Consumer-side words appear in strict push order. No word is dropped or duplicated.
  - `in_valid` while `in_ready`=0 is held off. It is not an error, and nothing is written.
  - Protocol assumption on the producer: once `in_valid` is asserted, it holds `in_data` stable until accepted.
  - The FIFO's own guarantee: `out_valid` and `out_data` remain stable until popped. No other event changes the head.
- Reset (asynchronous, `rst_n` low):
  - `wr_ptr`, `rd_ptr`, `count`, `peak` clear to 0 immediately.
  - Outputs during reset: `out_valid`=0, `out_data`=0, `in_ready`=0.
  - Array contents are not reset.
  - Reset mid-operation discards all stored words. No handshake completes while `rst_n` is low.
  - After release, `in_ready`=1 combinationally, and the first push can land on the first rising edge with `rst_n` high.

## Timing
- Latency: a word pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N, i.e. in cycle N+1.
  - The earliest pop of that word is at edge N+1.
  - There is no zero-cycle bypass when empty.
- Throughput: one push and one pop per cycle sustained while 0 < `count` < DEPTH.
- Full: `count`=DEPTH forces `in_ready`=0 in the same cycle. It returns to 1 in the cycle after the first pop.
- Empty: `count`=0 forces `out_valid`=0 and `out_data`=0 in the same cycle.
- Combinational paths:
  - `out_ready` → `in_ready`: none.
  - `in_valid` → `out_valid`: none.
- Pointer wrap: after DEPTH pushes, `wr_ptr` returns to 0. Ordering holds across any number of wraps.

## Test plan
- Reset values:
  - Assert `rst_n`=0 asynchronously mid-cycle → `count`=0, `peak`=0, `out_valid`=0, `out_data`=0, `in_ready`=0 without waiting for an edge.
  - Release reset → `in_ready`=1.
- Fill then drain:
  - Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `out_ready`=0 → `count`=4, `in_ready`=0, `peak`=4.
  - Hold a 5th word 0xDEADBEEF on `in_valid`=1 → not accepted.
  - Raise `out_ready` → outputs 0x11111111..0x44444444 in order, then 0xDEADBEEF.
- Streaming at full rate:
  - `in_valid`=1 and `out_ready`=1 continuously, with incrementing data 0..99 → first `out_valid` one cycle after first push.
  - All 100 words received in order; `count` stays ≤1 and `peak`=1.
- Wrap-around: 10 rounds of push 3 / pop 3 with DEPTH=4 → pointers wrap repeatedly, order preserved, `count` returns to 0 after each round.
- Full-cycle pop:
  - With `count`=4, assert `out_ready`=1 and `in_valid`=1 → that edge pops only, giving `count`=3.
  - Next edge pushes and pops together → `count` stays 3.
- Reset mid-operation:
  - With `count`=2, pulse `rst_n` low for 1 cycle → stored words are lost and `out_valid`=0.
  - After release, push 0xCAFEF00D → it is the next word out, and `peak` restarts from 0 to 1.
